// File: rtl/mmio_bus_arbiter.sv
// mmio_bus_arbiter: two-master MMIO sequencer with region decode, LED register and switch synchronizer.
// Define ARB_FIXED_PRIORITY_EN for fixed m0-first priority; round-robin otherwise.
module mmio_bus_arbiter #(
  parameter int OPERAND_LENGTH = 31,
  parameter int MEM_LATENCY = 1,
  parameter int LED_WIDTH = 16,
  parameter int SW_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    m0Req,
  input  logic                    m0We,
  input  logic [OPERAND_LENGTH:0] m0Addr,
  input  logic [OPERAND_LENGTH:0] m0WData,
  output logic                    m0Ack,
  output logic [OPERAND_LENGTH:0] m0RData,
  output logic                    m0Err,
  input  logic                    m1Req,
  input  logic                    m1We,
  input  logic [OPERAND_LENGTH:0] m1Addr,
  input  logic [OPERAND_LENGTH:0] m1WData,
  output logic                    m1Ack,
  output logic [OPERAND_LENGTH:0] m1RData,
  output logic                    m1Err,
  output logic                    memReq,
  output logic                    memWe,
  output logic [OPERAND_LENGTH:0] memAddr,
  output logic [OPERAND_LENGTH:0] memWData,
  input  logic [OPERAND_LENGTH:0] memRData,
  output logic [LED_WIDTH-1:0]    ledOut,
  input  logic [SW_WIDTH-1:0]     swIn,
  output logic                    busy
);
  localparam int W = OPERAND_LENGTH + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAITS, RESP} state_t;
  state_t state_q, state_d;
  logic id_q, id_d, last_q, last_d, we_q, we_d, err_q, err_d, grant;
  logic [W-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0] cnt_q, cnt_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [SW_WIDTH-1:0] sw_meta_q, sw_q;
  logic [1:0] region;
  assign region = addr_q[OPERAND_LENGTH -: 2];
`ifdef ARB_FIXED_PRIORITY_EN
  assign grant = !m0Req;
`else
  // grant 1 selects m1; on a tie the master that did not win last time goes
  assign grant = (m0Req && m1Req) ? !last_q : m1Req;
`endif
  always_ff @(posedge clk or negedge rstN)
    if (!rstN) begin
      state_q   <= IDLE;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_q      <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      last_q    <= last_d;
      we_q      <= we_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      led_q     <= led_d;
      sw_meta_q <= swIn;
      sw_q      <= sw_meta_q;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (m0Req || m1Req) ? ISSUE : IDLE;
      ISSUE:   state_d = (region == 2'b00 && !we_q) ? WAITS : RESP;
      WAITS:   state_d = (cnt_q == 4'd1) ? RESP : WAITS;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    id_d    = id_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    if (state_q == IDLE && (m0Req || m1Req)) begin
      id_d    = grant;
      last_d  = grant;
      we_d    = grant ? m1We : m0We;
      addr_d  = grant ? m1Addr : m0Addr;
      wdata_d = grant ? m1WData : m0WData;
    end
    if (state_q == ISSUE) begin
      rdata_d = '0;
      err_d   = region == 2'b11;
      cnt_d   = 4'(MEM_LATENCY);
      if (region == 2'b01 && we_q) led_d = wdata_q[LED_WIDTH-1:0];
      if (region == 2'b01 && !we_q) rdata_d = W'(led_q);
      if (region == 2'b10 && !we_q) rdata_d = W'(sw_q);
    end
    if (state_q == WAITS) begin
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) rdata_d = memRData;
    end
  end
  always_comb begin
    memReq   = state_q == ISSUE && region == 2'b00;
    memWe    = memReq && we_q;
    memAddr  = addr_q;
    memWData = wdata_q;
    m0Ack    = state_q == RESP && !id_q;
    m1Ack    = state_q == RESP && id_q;
    m0RData  = m0Ack ? rdata_q : '0;
    m1RData  = m1Ack ? rdata_q : '0;
    m0Err    = m0Ack && err_q;
    m1Err    = m1Ack && err_q;
    ledOut   = led_q;
    busy     = state_q != IDLE;
  end
endmodule
